// File: rtl/pkt_loopback_fifo.sv
// Packet loopback buffer: pkt_tx-style write side, FIFO, pkt_rx-style avail/ren read side.
// Optional statistics counters are built when PKT_LOOPBACK_STATS_EN is defined.
module pkt_loopback_fifo #(
   parameter int DEPTH_LOG2 = 6,
   parameter int FULL_SLACK = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_tx_val,
   input  logic        pkt_tx_sop,
   input  logic        pkt_tx_eop,
   input  logic [2:0]  pkt_tx_mod,
   input  logic [63:0] pkt_tx_data,
   output logic        pkt_tx_full,
   input  logic        pkt_rx_ren,
   output logic        pkt_rx_avail,
   output logic        pkt_rx_val,
   output logic        pkt_rx_sop,
   output logic        pkt_rx_eop,
   output logic        pkt_rx_err,
   output logic [2:0]  pkt_rx_mod,
   output logic [63:0] pkt_rx_data,
   output logic [31:0] stat_pkt_cnt,
   output logic [31:0] stat_drop_cnt
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

   state_t          state, state_next;
   logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic [PW-1:0]   pkt_cnt, free;
   logic            full_next;
   logic            wr_en, wr_force, wr_eop, pop, pop_eop;
   logic [2:0]      wr_mod;
   logic [63:0]     mem_data [DEPTH];
   logic [5:0]      mem_ctl  [DEPTH];

   logic            vld_p1, sop_p1, eop_p1, err_p1;
   logic [2:0]      mod_p1;
   logic [63:0]     data_p1;

   assign free = PW'(DEPTH) - (wr_ptr - rd_ptr);

   // Write FSM: the last free slot is always spent on an eop so no packet stays incomplete.
   // In PKT at least one slot is always free, because entering or staying there needs free >= 2.
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      wr_force   = 1'b0;
      if (pkt_tx_val) begin
         case (state)
            IDLE: begin
               if (pkt_tx_sop && free >= PW'(2)) begin
                  wr_en = 1'b1;
                  if (!pkt_tx_eop) state_next = PKT;
               end else if (pkt_tx_sop && free == PW'(1)) begin
                  wr_en    = 1'b1;
                  wr_force = 1'b1;
                  if (!pkt_tx_eop) state_next = DROP;
               end else if (pkt_tx_sop && !pkt_tx_eop) begin
                  state_next = DROP;
               end
            end
            PKT: begin
               wr_en = 1'b1;
               if (pkt_tx_sop) begin
                  wr_force   = 1'b1;
                  state_next = pkt_tx_eop ? IDLE : DROP;
               end else if (pkt_tx_eop) begin
                  state_next = IDLE;
               end else if (free < PW'(2)) begin
                  wr_force   = 1'b1;
                  state_next = DROP;
               end
            end
            DROP: begin
               if (pkt_tx_eop) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign wr_eop  = pkt_tx_eop | wr_force;
   assign wr_mod  = wr_force ? 3'd0 : pkt_tx_mod;
   assign pop     = pkt_rx_ren & (pkt_cnt != '0);
   assign pop_eop = mem_ctl[rd_ptr[DEPTH_LOG2-1:0]][4];

   assign wr_ptr_next = wr_ptr + PW'(wr_en);
   assign rd_ptr_next = rd_ptr + PW'(pop);
   assign full_next   = (PW'(DEPTH) - (wr_ptr_next - rd_ptr_next)) < PW'(FULL_SLACK);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr[DEPTH_LOG2-1:0]] <= pkt_tx_data;
         mem_ctl[wr_ptr[DEPTH_LOG2-1:0]]  <= {pkt_tx_sop, wr_eop, wr_mod, wr_force};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pkt_cnt     <= '0;
         pkt_tx_full <= 1'b0;
      end else begin
         state       <= state_next;
         wr_ptr      <= wr_ptr_next;
         rd_ptr      <= rd_ptr_next;
         pkt_tx_full <= full_next;
         case ({wr_en & wr_eop, pop & pop_eop})
            2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
            2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

   // Read stage p1: one-cycle latency, word fields hold when nothing is popped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         sop_p1  <= 1'b0;
         eop_p1  <= 1'b0;
         err_p1  <= 1'b0;
         mod_p1  <= 3'd0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= pop;
         if (pop) begin
            {sop_p1, eop_p1, mod_p1, err_p1} <= mem_ctl[rd_ptr[DEPTH_LOG2-1:0]];
            data_p1                          <= mem_data[rd_ptr[DEPTH_LOG2-1:0]];
         end
      end
   end

   assign pkt_rx_avail = (pkt_cnt != '0);
   assign pkt_rx_val   = vld_p1;
   assign pkt_rx_sop   = sop_p1;
   assign pkt_rx_eop   = eop_p1;
   assign pkt_rx_err   = err_p1;
   assign pkt_rx_mod   = mod_p1;
   assign pkt_rx_data  = data_p1;

`ifdef PKT_LOOPBACK_STATS_EN
   logic drop;
   assign drop = pkt_tx_val & ~wr_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_pkt_cnt  <= '0;
         stat_drop_cnt <= '0;
      end else begin
         if (wr_en && wr_eop && stat_pkt_cnt != 32'hFFFF_FFFF)
            stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
         if (drop && stat_drop_cnt != 32'hFFFF_FFFF)
            stat_drop_cnt <= stat_drop_cnt + 32'd1;
      end
   end
`else
   assign stat_pkt_cnt  = '0;
   assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_loopback_fifo.sv
// Directed bench for pkt_loopback_fifo (DEPTH_LOG2=3, FULL_SLACK=2).
module tb_pkt_loopback_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
   logic [2:0]  pkt_tx_mod;
   logic [63:0] pkt_tx_data;
   logic        pkt_tx_full;
   logic        pkt_rx_ren;
   logic        pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
   logic [2:0]  pkt_rx_mod;
   logic [63:0] pkt_rx_data;
   logic [31:0] stat_pkt_cnt, stat_drop_cnt;

   int tests = 0;
   int fails = 0;
   int drop_exp = 0;
   int pkt_exp = 0;

   always #5 clk = ~clk;

   pkt_loopback_fifo #(.DEPTH_LOG2(3), .FULL_SLACK(2)) dut (
      .clk(clk), .reset(reset),
      .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
      .pkt_tx_mod(pkt_tx_mod), .pkt_tx_data(pkt_tx_data), .pkt_tx_full(pkt_tx_full),
      .pkt_rx_ren(pkt_rx_ren), .pkt_rx_avail(pkt_rx_avail), .pkt_rx_val(pkt_rx_val),
      .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop), .pkt_rx_err(pkt_rx_err),
      .pkt_rx_mod(pkt_rx_mod), .pkt_rx_data(pkt_rx_data),
      .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic e,
                        input logic [2:0] m, input logic [63:0] d);
      pkt_tx_val  = v;
      pkt_tx_sop  = s;
      pkt_tx_eop  = e;
      pkt_tx_mod  = m;
      pkt_tx_data = d;
   endtask

   task automatic chk_stats(input string tag);
`ifdef PKT_LOOPBACK_STATS_EN
      chk({tag, "_stat_pkt"}, 64'(stat_pkt_cnt), 64'(pkt_exp));
      chk({tag, "_stat_drop"}, 64'(stat_drop_cnt), 64'(drop_exp));
`else
      chk({tag, "_stat_pkt"}, 64'(stat_pkt_cnt), 64'd0);
      chk({tag, "_stat_drop"}, 64'(stat_drop_cnt), 64'd0);
`endif
   endtask

   task automatic single_pkt(input logic [63:0] base);
      drive(1'b1, 1'b1, 1'b0, 3'd0, base);
      step();
      chk("sp_avail_w0", 64'(pkt_rx_avail), 64'd0);
      drive(1'b1, 1'b0, 1'b0, 3'd0, base + 64'd1);
      step();
      chk("sp_avail_w1", 64'(pkt_rx_avail), 64'd0);
      drive(1'b1, 1'b0, 1'b1, 3'd5, base + 64'd2);
      step();
      chk("sp_avail_rise", 64'(pkt_rx_avail), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
      pkt_rx_ren = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sp_val", 64'(pkt_rx_val), 64'd1);
         chk("sp_data", pkt_rx_data, base + 64'(i));
         chk("sp_sop", 64'(pkt_rx_sop), 64'(i == 0));
         chk("sp_eop", 64'(pkt_rx_eop), 64'(i == 2));
         chk("sp_err", 64'(pkt_rx_err), 64'd0);
         if (i == 2) chk("sp_mod", 64'(pkt_rx_mod), 64'd5);
      end
      chk("sp_avail_fall", 64'(pkt_rx_avail), 64'd0);
      pkt_rx_ren = 1'b0;
      step();
      chk("sp_val_end", 64'(pkt_rx_val), 64'd0);
      pkt_exp++;
      chk_stats("sp");
   endtask

   initial begin
      logic [63:0] pe_data [4];
      logic        pe_sop  [4];
      logic        pe_eop  [4];
      logic        pe_err  [4];
      logic [2:0]  pe_mod  [4];

      reset      = 1'b1;
      pkt_rx_ren = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
      repeat (2) step();
      chk("rst_full", 64'(pkt_tx_full), 64'd0);
      chk("rst_avail", 64'(pkt_rx_avail), 64'd0);
      chk("rst_val", 64'(pkt_rx_val), 64'd0);
      chk("rst_sop", 64'(pkt_rx_sop), 64'd0);
      chk("rst_eop", 64'(pkt_rx_eop), 64'd0);
      chk("rst_err", 64'(pkt_rx_err), 64'd0);
      chk("rst_mod", 64'(pkt_rx_mod), 64'd0);
      chk("rst_data", pkt_rx_data, 64'd0);
      chk_stats("rst");
      reset = 1'b0;
      step();

      // Orphan word while idle
      drive(1'b1, 1'b0, 1'b0, 3'd0, 64'hDEAD);
      step();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
      drop_exp = 1;
      chk("orph_avail", 64'(pkt_rx_avail), 64'd0);
      step();
      chk("orph_avail2", 64'(pkt_rx_avail), 64'd0);
      chk_stats("orph");

      // Single packet
      single_pkt(64'h1111_0000_0000_0000);

      // Overflow: 10-word packet into an 8-entry FIFO
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 1'(i == 1), 1'(i == 10), (i == 10) ? 3'd3 : 3'd0,
               64'hA000_0000_0000_0000 + 64'(i));
         step();
         chk("ov_full", 64'(pkt_tx_full), 64'(i >= 7));
      end
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
      drop_exp += 2;
      pkt_exp++;
      chk("ov_avail", 64'(pkt_rx_avail), 64'd1);
      chk_stats("ov");
      pkt_rx_ren = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("ov_val", 64'(pkt_rx_val), 64'd1);
         chk("ov_data", pkt_rx_data, 64'hA000_0000_0000_0000 + 64'(i));
         chk("ov_sop", 64'(pkt_rx_sop), 64'(i == 1));
         chk("ov_eop", 64'(pkt_rx_eop), 64'(i == 8));
         chk("ov_err", 64'(pkt_rx_err), 64'(i == 8));
         chk("ov_mod", 64'(pkt_rx_mod), 64'd0);
      end
      chk("ov_avail_end", 64'(pkt_rx_avail), 64'd0);
      pkt_rx_ren = 1'b0;
      step();
      chk("ov_val_end", 64'(pkt_rx_val), 64'd0);
      chk("ov_full_end", 64'(pkt_tx_full), 64'd0);

      // Protocol error: sop inside a packet, then drop up to the next eop
      drive(1'b1, 1'b1, 1'b0, 3'd0, 64'hB0); step();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 64'hB1); step();
      drive(1'b1, 1'b1, 1'b0, 3'd6, 64'hB2); step();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 64'hB3); step();
      drive(1'b1, 1'b0, 1'b1, 3'd2, 64'hB4); step();
      drive(1'b1, 1'b1, 1'b1, 3'd3, 64'hC0); step();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
      drop_exp += 2;
      pkt_exp  += 2;
      chk_stats("pe");
      pe_data[0] = 64'hB0; pe_sop[0] = 1'b1; pe_eop[0] = 1'b0; pe_err[0] = 1'b0; pe_mod[0] = 3'd0;
      pe_data[1] = 64'hB1; pe_sop[1] = 1'b0; pe_eop[1] = 1'b0; pe_err[1] = 1'b0; pe_mod[1] = 3'd0;
      pe_data[2] = 64'hB2; pe_sop[2] = 1'b1; pe_eop[2] = 1'b1; pe_err[2] = 1'b1; pe_mod[2] = 3'd0;
      pe_data[3] = 64'hC0; pe_sop[3] = 1'b1; pe_eop[3] = 1'b1; pe_err[3] = 1'b0; pe_mod[3] = 3'd3;
      pkt_rx_ren = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("pe_val", 64'(pkt_rx_val), 64'd1);
         chk("pe_data", pkt_rx_data, pe_data[i]);
         chk("pe_sop", 64'(pkt_rx_sop), 64'(pe_sop[i]));
         chk("pe_eop", 64'(pkt_rx_eop), 64'(pe_eop[i]));
         chk("pe_err", 64'(pkt_rx_err), 64'(pe_err[i]));
         chk("pe_mod", 64'(pkt_rx_mod), 64'(pe_mod[i]));
      end
      step();
      chk("pe_val_end", 64'(pkt_rx_val), 64'd0);
      chk("pe_avail_end", 64'(pkt_rx_avail), 64'd0);

      // Streaming: 100 single-word packets with ren held high
      for (int k = 0; k < 100; k++) begin
         drive(1'b1, 1'b1, 1'b1, 3'(k), 64'h5000 + 64'(k));
         step();
         chk("st_full", 64'(pkt_tx_full), 64'd0);
         if (k >= 1) begin
            chk("st_val", 64'(pkt_rx_val), 64'd1);
            chk("st_data", pkt_rx_data, 64'h5000 + 64'(k - 1));
         end
      end
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
      step();
      chk("st_val_last", 64'(pkt_rx_val), 64'd1);
      chk("st_data_last", pkt_rx_data, 64'h5000 + 64'd99);
      step();
      chk("st_val_end", 64'(pkt_rx_val), 64'd0);
      chk("st_avail_end", 64'(pkt_rx_avail), 64'd0);
      pkt_exp += 100;
      chk_stats("st");
      pkt_rx_ren = 1'b0;

      // Reset mid-read with two packets buffered (6 words + 1 word fills to full)
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'(i == 0), 1'(i == 5), 3'd0, 64'hE0 + 64'(i));
         step();
      end
      drive(1'b1, 1'b1, 1'b1, 3'd1, 64'hF0);
      step();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
      chk("rr_full_pre", 64'(pkt_tx_full), 64'd1);
      chk("rr_avail_pre", 64'(pkt_rx_avail), 64'd1);
      pkt_rx_ren = 1'b1;
      step();
      chk("rr_val_pre", 64'(pkt_rx_val), 64'd1);
      chk("rr_data_pre", pkt_rx_data, 64'hE0);
      #2;
      reset = 1'b1;
      #1;
      chk("rr_val", 64'(pkt_rx_val), 64'd0);
      chk("rr_avail", 64'(pkt_rx_avail), 64'd0);
      chk("rr_full", 64'(pkt_tx_full), 64'd0);
      chk("rr_data", pkt_rx_data, 64'd0);
      pkt_exp  = 0;
      drop_exp = 0;
      chk_stats("rr");
      pkt_rx_ren = 1'b0;
      step();
      reset = 1'b0;
      step();
      single_pkt(64'h2222_0000_0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pkt_loopback_fifo.md
# pkt_loopback_fifo

Synthesizable packet loopback buffer that acts as the far end of both client packet interfaces of the 10G Ethernet MAC. It accepts packets on a pkt_tx-style interface, applying backpressure through pkt_tx_full. It buffers them in an on-chip FIFO and presents complete packets on a pkt_rx-style interface with the avail/ren read handshake. It serves as a MAC stand-in for client-side logic and for bench self-checks.

## Interface
- DEPTH_LOG2, 6, FIFO depth is 2**DEPTH_LOG2 words; each word holds data[63:0], sop, eop, mod[2:0] and err.
- FULL_SLACK, 4, pkt_tx_full asserts when free entries < FULL_SLACK; legal range is 2 to 2**DEPTH_LOG2-1.
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- pkt_tx_val / pkt_tx_sop / pkt_tx_eop  input  1 each  write word valid / start / end of packet.
- pkt_tx_mod  input  3  valid bytes on the eop word; 0 means all 8 bytes.
- pkt_tx_data  input  64  write data.
- pkt_tx_full  output  1  backpressure.
- pkt_rx_ren  input  1  read enable.
- pkt_rx_avail  output  1  at least one complete packet is buffered.
- pkt_rx_val / pkt_rx_sop / pkt_rx_eop / pkt_rx_err  output  1 each  read word qualifiers.
- pkt_rx_mod  output  3; pkt_rx_data  output  64.
- stat_pkt_cnt  output  32; stat_drop_cnt  output  32  statistics, see Configuration.

## Operation
Write FSM has three states: IDLE, PKT and DROP. "free" is the number of free FIFO entries, taken from the current registered state. Every word is written unmodified except where a rule below says otherwise.

- **IDLE, val & !sop:** the word is dropped (drop count +1) and the state stays IDLE.
- **IDLE, val & sop, free ≥ 2:** the word is written. If eop is set, stay in IDLE; otherwise go to PKT.
- **IDLE, val & sop, free == 1:** the word is written with eop=1, err=1, mod=0. Go to IDLE if the input eop was set, otherwise DROP.
- **IDLE, val & sop, free == 0:** the word is dropped. Go to IDLE if eop, otherwise DROP.
- **PKT, val & !sop & eop:** the word is written and the state returns to IDLE.
- **PKT, val & !sop & !eop:** the word is written if free ≥ 2. If free == 1, it is written as a forced eop with err=1 and mod=0, and the state goes to DROP.
- **PKT, val & sop (protocol error):** the word is written as a forced eop with err=1 and mod=0, closing the prior packet. Go to DROP, or to IDLE if the word also carried eop.
- **DROP:** every val word is dropped (+1 each). Return to IDLE on a word with eop.

These rules guarantee the last free slot always terminates a packet, so a packet can never be left permanently incomplete.

- pkt_cnt (DEPTH_LOG2+1 bits) counts buffered eop words: +1 on an eop write, -1 on an eop pop, unchanged when both happen in the same cycle.
- pkt_rx_avail = (pkt_cnt != 0).
- **Pop condition:** pkt_rx_ren & (pkt_cnt != 0), using registered pkt_cnt. Because packets are stored contiguously, the head word always belongs to a complete packet. Popping continues across packets while ren stays high and pkt_cnt is nonzero.
- pkt_rx_err is set only on eop words of forcibly terminated packets. pkt_rx_mod is meaningful only when pkt_rx_eop=1.
- A simultaneous read and write is legal at any fill level. free changes by the net amount.

## Timing
- **Reset:** all outputs are 0, including pkt_tx_full, pkt_rx_avail, pkt_rx_val and the stats. FIFO is empty, pkt_cnt=0, FSM is in IDLE.
- **Write:** the write is accepted at the clk edge when pkt_tx_val=1. The word becomes visible to reads from the next cycle.
- **Full flag:** pkt_tx_full is registered and reflects occupancy one cycle after the causing write or pop. A source that keeps writing after full asserts is covered by the free==1 and free==0 rules.
- **Avail flag:** pkt_rx_avail asserts the cycle after the eop write. It deasserts the cycle after the last buffered eop is popped.
- **Read latency:** exactly 1 cycle. A pop at edge N produces pkt_rx_val=1 with the word from N+1 until the next edge. Otherwise pkt_rx_val=0 and the other outputs hold their last values.
- **Pointer wrap:** pointers wrap modulo 2**DEPTH_LOG2. Full and empty are distinguished by an extra pointer bit.
- **Reset mid-packet:** asynchronous reset discards all buffered words and immediately forces every output to 0.

## Configuration
- **PKT_LOOPBACK_STATS_EN defined:**
  - stat_pkt_cnt increments on every eop written.
  - stat_drop_cnt increments on every dropped word.
  - Both saturate at 2**32-1 and reset to 0.
- **PKT_LOOPBACK_STATS_EN undefined:** both stat outputs are tied to 0 and no counter logic is built.

## Test plan
- **Single packet:** after reset, write a 3-word packet (sop at word 0, eop with mod=5 at word 2), then hold ren=1. Required: avail rises 1 cycle after the eop write, 3 val cycles follow with matching data, sop/eop and mod=5, err=0, and avail then drops.
- **Overflow:** DEPTH_LOG2=3, FULL_SLACK=2, ren=0; write a 10-word packet. Required: full asserts after the 7th word is written; the 8th word is stored with eop=1, err=1, mod=0; words 9-10 are dropped; stat_drop_cnt=2.
- **Protocol error:** mid-packet sop. Required: the sop word is stored as an err eop, and all following words up to the next eop are dropped.
- **Orphan word:** a val word without sop while idle. Required: the word is dropped, avail stays 0, stat_drop_cnt=1.
- **Streaming:** write and pop 100 back-to-back single-word packets while holding ren=1 throughout. Required: no drops, full never asserts, and output order equals input order.
- **Reset mid-read:** assert reset mid-read with 2 packets buffered. Required: val, avail and full go to 0 immediately, and the next write after reset behaves as in the single-packet scenario.
